// File: rtl/div16s_by8s_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// master drives operands and result-ready; slave is the divider.
interface div16s_by8s_seq_if #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  overflow;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
  );
endinterface

// File: rtl/div16s_by8s_seq.sv
// Sequential signed divider: 16-bit dividend by 8-bit divisor, radix-2
// restoring on magnitudes, one quotient bit per cycle, sign fix-up at the end.
module div16s_by8s_seq #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  div16s_by8s_seq_if.slave        bus
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
  localparam int unsigned Q_LIM = 2 ** (DIVISOR_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;   // dividend magnitude, shifted out MSB first
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] qmag_q, qmag_d;
  logic                  sn_q, sn_d;
  logic                  sd_q, sd_d;
  logic [DIVISOR_W-1:0]  dlo_q, dlo_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
  logic                  ovf_q, ovf_d;
  logic                  dbz_q, dbz_d;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic [DIVISOR_W:0]    shifted;
  logic                  fits;
  logic                  q_neg;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qmag_d  = qmag_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    dlo_d   = dlo_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    shifted = {rem_q, dvd_q[DIVIDEND_W-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    q_neg   = sn_q ^ sd_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sn_d   = bus.dividend[DIVIDEND_W-1];
          sd_d   = bus.divisor[DIVISOR_W-1];
          dvd_d  = bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + DIVIDEND_W'(1)) : bus.dividend;
          dvs_d  = bus.divisor[DIVISOR_W-1] ? (~bus.divisor + DIVISOR_W'(1)) : bus.divisor;
          dlo_d  = bus.dividend[DIVISOR_W-1:0];
          rem_d  = '0;
          qmag_d = '0;
          cnt_d  = CNT_W'(DIVIDEND_W - 1);
          state_d = (bus.divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        qmag_d = {qmag_q[DIVIDEND_W-2:0], fits};
        rem_d  = fits ? DIVISOR_W'(shifted - {1'b0, dvs_q}) : DIVISOR_W'(shifted);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (dvs_q == '0) begin
          quo_d = '1;
          rmd_d = dlo_q;
          ovf_d = 1'b1;
          dbz_d = 1'b1;
        end else begin
          quo_d = q_neg ? (~qmag_q + DIVIDEND_W'(1)) : qmag_q;
          rmd_d = sn_q ? (~rem_q + DIVISOR_W'(1)) : rem_q;
          // Negative quotients may reach one further magnitude than positive ones
          ovf_d = q_neg ? (qmag_q > DIVIDEND_W'(Q_LIM)) : (qmag_q > DIVIDEND_W'(Q_LIM - 1));
          dbz_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      qmag_q      <= '0;
      sn_q        <= 1'b0;
      sd_q        <= 1'b0;
      dlo_q       <= '0;
      quo_q       <= '0;
      rmd_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      qmag_q      <= qmag_d;
      sn_q        <= sn_d;
      sd_q        <= sd_d;
      dlo_q       <= dlo_d;
      quo_q       <= quo_d;
      rmd_q       <= rmd_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16s_by8s_seq.sv
// Bench for div16s_by8s_seq: directed corner cases plus random operands
// compared against an integer-arithmetic reference.
module tb_div16s_by8s_seq;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  div16s_by8s_seq_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

  div16s_by8s_seq #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed integer division truncates toward zero; remainder takes the dividend's sign
  function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic ov, output logic dz);
    int sa, sb, iq, ir;
    if (b == 8'h00) begin
      q = 16'hFFFF; r = a[7:0]; ov = 1'b1; dz = 1'b1;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      iq = sa / sb;
      ir = sa % sb;
      q  = 16'(iq);
      r  = 8'(ir);
      ov = (iq > 127) || (iq < -128);
      dz = 1'b0;
    end
  endfunction

  task automatic check_result(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        eo, ez;
    ref_div(a, b, eq, er, eo, ez);
    chk("quotient",    32'(bus.quotient),    32'(eq));
    chk("remainder",   32'(bus.remainder),   32'(er));
    chk("overflow",    32'(bus.overflow),    32'(eo));
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(ez));
  endtask

  // Accept one operand pair, then count edges until out_valid
  task automatic launch(input logic [15:0] a, input logic [7:0] b, output int lat);
    int guard;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin tick(); guard++; end
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b);
    int lat;
    launch(a, b, lat);
    chk("latency", 32'(lat), (b == 8'h00) ? 32'd1 : 32'd17);
    check_result(a, b);
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  s;
    n_vec  = 0;
    n_miss = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",    32'(bus.in_ready),    32'd1);
    chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
    chk("rst_quotient",    32'(bus.quotient),    32'd0);
    chk("rst_remainder",   32'(bus.remainder),   32'd0);
    chk("rst_overflow",    32'(bus.overflow),    32'd0);
    chk("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed corner cases
    run_op(16'hFD44, 8'hF9);
    chk("rt_quotient", 32'(bus.quotient), 32'h0064);
    run_op(16'hF9FF, 8'h0C);
    chk("neg128_quotient", 32'(bus.quotient), 32'hFF80);
    chk("neg128_overflow", 32'(bus.overflow), 32'd0);
    run_op(16'h0601, 8'h0C);
    chk("pos128_overflow", 32'(bus.overflow), 32'd1);
    run_op(16'h03E8, 8'h00);
    chk("dbz_remainder", 32'(bus.remainder), 32'h00E8);
    run_op(16'h8000, 8'hFF);
    chk("minint_quotient", 32'(bus.quotient), 32'h8000);

    // Backpressure with a new request held off behind the pending result
    launch(16'hFD44, 8'hF9, lat);
    bus.in_valid  = 1'b1;
    bus.dividend  = 16'd100;
    bus.divisor   = 8'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check_result(16'hFD44, 8'hF9);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_accepted", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick(); lat++; end
    chk("bp_latency", 32'(lat), 32'd17);
    chk("bp_quotient",  32'(bus.quotient),  32'h0021);
    chk("bp_remainder", 32'(bus.remainder), 32'h0001);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset mid-calculation
    bus.dividend = 16'hFD44;
    bus.divisor  = 8'hF9;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_quotient",  32'(bus.quotient),  32'd0);
    chk("mid_rst_remainder", 32'(bus.remainder), 32'd0);
    chk("mid_rst_overflow",  32'(bus.overflow),  32'd0);
    chk("mid_rst_dbz",       32'(bus.div_by_zero), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(16'hFF80, 8'h02);
    chk("post_rst_quotient", 32'(bus.quotient), 32'hFFC0);

    // Random operands, biased toward small dividends and occasional zero divisors
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      s = 8'($urandom);
      if (i % 3 == 0) a = {{8{s[7]}}, s};
      if (i % 10 == 0) b = 8'h00;
      run_op(a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
